// File: rtl/bcd_xs3_pkg.sv
// Shared constants, state encoding and helpers for the digit-serial BCD/XS3 converter.
// Optional invalid-code detection is enabled by defining BCD_XS3_ERR_EN.
package bcd_xs3_pkg;

  localparam logic       MODE_BCD2XS3 = 1'b0;
  localparam logic       MODE_XS32BCD = 1'b1;
  localparam logic [3:0] XS3_OFFSET   = 4'd3;
  localparam logic [3:0] DIGIT_BAD    = 4'hF;

  // Legal code ranges: BCD 0..9, XS3 3..12.
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Digit counter width; a single-digit word still needs a 1-bit counter.
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_xs3_digit.sv
// Combinational single-nibble BCD<->XS3 converter.
// With BCD_XS3_ERR_EN defined, illegal codes yield DIGIT_BAD and raise err.
module bcd_xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       mode,
  output logic [3:0] nibble
`ifdef BCD_XS3_ERR_EN
  ,
  output logic       err
`endif
);

  // Plain 4-bit add/subtract wraps modulo 16 when no checking is built in.
  always_comb begin
    nibble = (mode == MODE_XS32BCD) ? (digit - XS3_OFFSET) : (digit + XS3_OFFSET);
`ifdef BCD_XS3_ERR_EN
    err = (mode == MODE_XS32BCD) ? ((digit < XS3_MIN) || (digit > XS3_MAX))
                                 : (digit > BCD_MAX);
    if (err) begin
      nibble = DIGIT_BAD;
    end
`endif
  end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Digit-serial packed BCD<->XS3 converter, one nibble per clock, LSD first.
// Define BCD_XS3_ERR_EN to add the out_err port and invalid-code detection.
module bcd_xs3_serial_conv
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
`ifdef BCD_XS3_ERR_EN
  output logic [DIGITS-1:0]     out_err,
`endif
  output logic                  busy
);

  localparam int               CNT_W    = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] word_q;
  logic [4*DIGITS-1:0] data_q;
  logic                mode_q;
  logic [3:0]          cur_digit;
  logic [3:0]          cur_nibble;
  logic                accept;
  logic                last_digit;
`ifdef BCD_XS3_ERR_EN
  logic [DIGITS-1:0]   err_q;
  logic                cur_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs depend on the registered state alone.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (last_digit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept     = in_valid && (state_q == IDLE);
  assign last_digit = (cnt_q == CNT_LAST);

  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        cur_digit = word_q[4*k +: 4];
      end
    end
  end

  bcd_xs3_digit u_digit (
    .digit  (cur_digit),
    .mode   (mode_q),
`ifdef BCD_XS3_ERR_EN
    .err    (cur_err),
`endif
    .nibble (cur_nibble)
  );

  // The counter parks on the last digit rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
      mode_q <= MODE_BCD2XS3;
      data_q <= '0;
`ifdef BCD_XS3_ERR_EN
      err_q  <= '0;
`endif
    end else if (accept) begin
      cnt_q  <= '0;
      word_q <= in_data;
      mode_q <= mode;
`ifdef BCD_XS3_ERR_EN
      err_q  <= '0;
`endif
    end else if (state_q == CONV) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          data_q[4*k +: 4] <= cur_nibble;
`ifdef BCD_XS3_ERR_EN
          err_q[k]         <= cur_err;
`endif
        end
      end
      if (!last_digit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_data = data_q;
`ifdef BCD_XS3_ERR_EN
  assign out_err  = err_q;
`endif

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Randomised and directed bench for bcd_xs3_serial_conv against a word-level model.
// Builds with or without BCD_XS3_ERR_EN.
module tb_bcd_xs3_serial_conv;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
`ifdef BCD_XS3_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          mode      = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [W-1:0]  out_data;
`ifdef BCD_XS3_ERR_EN
  logic [DIGITS-1:0] out_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_xs3_serial_conv #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BCD_XS3_ERR_EN
    .out_err   (out_err),
`endif
    .busy      (busy)
  );

  // Word-level reference: returns {err_flags, data}.
  function automatic logic [W+DIGITS-1:0] modelConv(input logic m, input logic [W-1:0] w);
    logic [W-1:0]      data;
    logic [DIGITS-1:0] err;
    data = '0;
    err  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      int d;
      int r;
      bit e;
      d = int'(w[4*k +: 4]);
      e = 1'b0;
      if (m == 1'b0) begin
        r = (d + 3) % 16;
        if (ERR_EN && d > 9) e = 1'b1;
      end else begin
        r = (d + 13) % 16;
        if (ERR_EN && (d < 3 || d > 12)) e = 1'b1;
      end
      if (e) r = 15;
      data[4*k +: 4] = 4'(r);
      err[k]         = e;
    end
    return {err, data};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Continuous compare against the model on every falling edge.
  bit                have_word = 1'b0;
  int                acc_idx   = 0;
  int                idx       = 0;
  logic [W-1:0]      exp_data  = '0;
  logic [DIGITS-1:0] exp_err   = '0;

  always @(negedge clk) begin
    bit exp_valid;
    if (!rst_n) begin
      have_word = 1'b0;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out_data", out_data, 0);
`ifdef BCD_XS3_ERR_EN
      checkOutput("rst_out_err", out_err, 0);
`endif
    end else begin
      exp_valid = have_word && (idx >= acc_idx + DIGITS + 1);
      checkOutput("mon_in_ready", in_ready, !have_word);
      checkOutput("mon_busy", busy, have_word);
      checkOutput("mon_out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        checkOutput("mon_out_data", out_data, exp_data);
`ifdef BCD_XS3_ERR_EN
        checkOutput("mon_out_err", out_err, exp_err);
`endif
      end
      if (!have_word && in_valid) begin
        have_word            = 1'b1;
        acc_idx              = idx;
        {exp_err, exp_data}  = modelConv(mode, in_data);
      end else if (exp_valid && out_ready) begin
        have_word = 1'b0;
      end
    end
    idx++;
  end

  // Called in the drive phase; returns in the drive phase just after the accept edge.
  task automatic applyStimulus(input logic m, input logic [W-1:0] d);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    checkOutput("accept", accepted, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 50 && !in_ready; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle_reached", in_ready, 1);
  endtask

  logic [W-1:0]      tbl_data [2];
  logic              tbl_mode [2];
  logic [W-1:0]      tbl_want [2];
  logic [DIGITS-1:0] tbl_err  [2];
  int                acc [8];
  int                n_acc;
  int                lat;
  bit                done;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl_data[0] = 16'h12A9; tbl_mode[0] = 1'b0;
    tbl_data[1] = 16'h3D02; tbl_mode[1] = 1'b1;
`ifdef BCD_XS3_ERR_EN
    tbl_want[0] = 16'h45FC; tbl_err[0] = 4'b0010;
    tbl_want[1] = 16'h0FFF; tbl_err[1] = 4'b0111;
`else
    tbl_want[0] = 16'h45DC; tbl_err[0] = 4'b0000;
    tbl_want[1] = 16'h0ADF; tbl_err[1] = 4'b0000;
`endif

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Pin the model to hand-derived values.
    checkOutput("model_1234", modelConv(1'b0, 16'h1234), {4'b0000, 16'h4567});
    checkOutput("model_4567", modelConv(1'b1, 16'h4567), {4'b0000, 16'h1234});
    checkOutput("model_0009", modelConv(1'b0, 16'h0009), {4'b0000, 16'h333C});
    for (int i = 0; i < 2; i++) begin
      checkOutput("model_err_tbl", modelConv(tbl_mode[i], tbl_data[i]), {tbl_err[i], tbl_want[i]});
    end

    @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'h1234);
    waitResult(lat);
    checkOutput("latency_1234", lat, DIGITS);
    checkOutput("data_1234", out_data, 16'h4567);
`ifdef BCD_XS3_ERR_EN
    checkOutput("err_1234", out_err, 0);
`endif
    @(posedge clk);
    #1;
    checkOutput("ready_after_hs", in_ready, 1);

    applyStimulus(1'b1, 16'h4567);
    waitResult(lat);
    checkOutput("latency_4567", lat, DIGITS);
    checkOutput("data_4567", out_data, 16'h1234);
    @(posedge clk);
    #1;

    // Back-to-back issue with in_valid held high.
    in_valid = 1'b1;
    mode     = 1'b1;
    in_data  = 16'h4567;
    n_acc    = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready && n_acc < 8) begin
        acc[n_acc] = c;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("b2b_count", n_acc, 4);
    for (int i = 1; i < n_acc && i < 4; i++) begin
      checkOutput("b2b_period", acc[i] - acc[i-1], DIGITS + 2);
    end
    waitIdle();

    for (int i = 0; i < 2; i++) begin
      applyStimulus(tbl_mode[i], tbl_data[i]);
      waitResult(lat);
      checkOutput("err_tbl_data", out_data, tbl_want[i]);
`ifdef BCD_XS3_ERR_EN
      checkOutput("err_tbl_flags", out_err, tbl_err[i]);
`endif
      @(posedge clk);
      #1;
    end

    // Stall the sink in HOLD while another word is offered.
    out_ready = 1'b0;
    applyStimulus(1'b0, 16'h2468);
    waitResult(lat);
    for (int c = 0; c < 5; c++) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_data, 16'h579B);
      checkOutput("hold_in_ready", in_ready, 0);
      if (c == 0) begin
        in_valid = 1'b1;
        mode     = 1'b0;
        in_data  = 16'h9999;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("hold_valid_end", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hold_release_ready", in_ready, 1);
    checkOutput("hold_release_busy", busy, 0);
    @(posedge clk);
    #1;
    checkOutput("no_9999_accept", busy, 0);

    // Reset in the middle of a conversion.
    applyStimulus(1'b0, 16'h8765);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_data", out_data, 0);
`ifdef BCD_XS3_ERR_EN
    checkOutput("midrst_out_err", out_err, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0009);
    waitResult(lat);
    checkOutput("latency_0009", lat, DIGITS);
    checkOutput("data_0009", out_data, 16'h333C);
    @(posedge clk);
    #1;

    // Random words with random idle gaps and sink back-pressure.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom));
      done = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          done = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      checkOutput("rand_handshake", done, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
